// File: rtl/clk_sw_pkg.sv
// Shared types and target-selection helper
// for the clock-switch selection controller.
package clk_sw_pkg;

  localparam int unsigned MAX_CLK_NUM = 32;
  localparam int unsigned MAX_SEL_W   = $clog2(MAX_CLK_NUM);

  typedef enum logic {
    STABLE,
    HOLD
  } state_t;

  // Unused high fail bits must be set by the caller
  function automatic logic [MAX_SEL_W-1:0] pick_target(
    input logic [MAX_SEL_W-1:0]   pref,
    input logic [MAX_CLK_NUM-1:0] fail
  );
    logic [MAX_SEL_W-1:0] t;
    t = '0;
    if (pref != '0) begin
      if (!fail[pref]) begin
        t = pref;
      end else begin
        for (int j = MAX_CLK_NUM - 1; j >= 1; j--) begin
          if (!fail[j]) t = j[MAX_SEL_W-1:0];
        end
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/clk_switch_sel_ctrl_filter.sv
// Per-clock fail flag: 2-flop synchronizer
// followed by a symmetric hysteresis counter.
module clk_fail_filter #(
  parameter int unsigned FAIL_FILT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_fail
);

  localparam int unsigned    CW   = $clog2(FAIL_FILT + 1);
  localparam logic [CW-1:0]  LAST = CW'(FAIL_FILT - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_fail <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_fail) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_fail <= ~r_fail;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_fail = r_fail;

endmodule

// File: rtl/clk_switch_sel_ctrl.sv
// Select controller in front of the glitch-free clock switch:
// request handshake, fail filtering, failover and hold-off.
module clk_switch_sel_ctrl
  import clk_sw_pkg::*;
#(
  parameter int unsigned  CLK_NUM     = 4,
  parameter int unsigned  FAIL_FILT   = 4,
  parameter int unsigned  HOLD_CYCLES = 8,
  parameter int unsigned  RESET_SEL   = 1,
  localparam int unsigned SEL_W       = $clog2(CLK_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CLK_NUM-1:0] clk_fail_i,
  input  logic               req_valid,
  input  logic [SEL_W-1:0]   req_sel,
  output logic               req_ready,
  output logic               req_err,
  output logic [SEL_W-1:0]   sel,
  output logic [CLK_NUM-1:0] clk_fail,
  output logic [SEL_W-1:0]   cur_pref,
  output logic               busy,
  output logic               switch_evt,
  output logic               failover,
  output logic               all_fail
);

  localparam int unsigned   CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_SEL);
  localparam logic [SEL_W:0]   NUM    = (SEL_W + 1)'(CLK_NUM);

  state_t           r_state, w_state;
  logic [SEL_W-1:0] r_sel, w_sel;
  logic [SEL_W-1:0] r_pref, w_pref;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic             r_err, w_err;
  logic             r_evt, w_evt;
  logic             r_fo, w_fo;

  logic [CLK_NUM-1:0]     w_fail;
  logic [MAX_CLK_NUM-1:0] w_fail_ext;
  logic [SEL_W-1:0]       w_target;
  logic                   w_req_bad;
  logic                   w_unused;

  assign w_fail[0] = 1'b0;
  assign w_unused  = clk_fail_i[0];

  for (genvar i = 1; i < CLK_NUM; i++) begin : g_filt
    clk_fail_filter #(
      .FAIL_FILT(FAIL_FILT)
    ) u_filt (
      .clk   (clk),
      .rst   (rst),
      .i_raw (clk_fail_i[i]),
      .o_fail(w_fail[i])
    );
  end

  // Absent indices look failed so they are never chosen
  always_comb begin
    w_fail_ext = '1;
    w_fail_ext[CLK_NUM-1:0] = w_fail;
  end

  assign w_target  = SEL_W'(pick_target(MAX_SEL_W'(r_pref), w_fail_ext));
  assign w_req_bad = {1'b0, req_sel} >= NUM;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STABLE;
      r_sel   <= RST_SEL;
      r_pref  <= RST_SEL;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_evt   <= 1'b0;
      r_fo    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_pref  <= w_pref;
      r_cnt   <= w_cnt;
      r_err   <= w_err;
      r_evt   <= w_evt;
      r_fo    <= w_fo;
    end
  end

  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_pref  = r_pref;
    w_cnt   = r_cnt;
    w_err   = 1'b0;
    w_evt   = 1'b0;
    w_fo    = 1'b0;
    unique case (r_state)
      STABLE: begin
        if (req_valid) begin
          w_pref = w_req_bad ? '0 : req_sel;
          w_err  = w_req_bad;
        end
        if (w_target != r_sel) begin
          w_sel   = w_target;
          w_evt   = 1'b1;
          w_fo    = (w_target != r_pref);
          w_cnt   = HOLD_LAST;
          w_state = HOLD;
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state = STABLE;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      default: w_state = STABLE;
    endcase
  end

  assign req_ready  = (r_state == STABLE);
  assign busy       = (r_state == HOLD);
  assign req_err    = r_err;
  assign sel        = r_sel;
  assign cur_pref   = r_pref;
  assign clk_fail   = w_fail;
  assign switch_evt = r_evt;
  assign failover   = r_fo;
  assign all_fail   = (r_pref != '0) && (w_target == '0);

endmodule
